data_setup: RTL and testbench
=============================

DATA_SETUP -- requirements
Module: data_setup

Interface
REQ-001 SHALL have parameter LANES, default 16, number of systolic-array input lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per lane element.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, unified-buffer address width (256 rows).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to stream a block of rows.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first buffer row; sampled with start.
REQ-008 SHALL have port num_rows  input  ADDR_WIDTH+1  row count, 0..256; sampled with start.
REQ-009 SHALL have port busy  output  1  high from start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port buf_rd_en  output  1  unified-buffer read enable.
REQ-012 SHALL have port buf_rd_addr  output  ADDR_WIDTH  unified-buffer read address.
REQ-013 SHALL have port buf_rd_data  input  LANES*DATA_WIDTH  unified-buffer read data; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port out_data  output  LANES*DATA_WIDTH  skewed array feed, same lane packing.
REQ-015 SHALL have port out_lane_valid  output  LANES  per-lane valid mask for out_data.

Function
REQ-016 SHALL treat buffer read latency as 1 cycle: data for buf_rd_addr driven with buf_rd_en at edge n is valid on buf_rd_data at edge n+1.
REQ-017 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: start=1 with num_rows>0 at edge t SHALL latch base_addr/num_rows, assert busy, go to READ.
REQ-019 IDLE: start=1 with num_rows=0 SHALL go to DONE without any buf_rd_en assertion.
REQ-020 READ SHALL issue row k (k=0..N-1) at edge t+1+k: buf_rd_en=1, buf_rd_addr=(base_addr+k) mod 2^ADDR_WIDTH.
REQ-021 After issuing row N-1, SHALL go to DRAIN; buf_rd_en=0 outside READ.
REQ-022 Lane i of row k SHALL appear on out_data with out_lane_valid[i]=1 at edge t+3+k+i (capture register plus i skew stages).
REQ-023 Lanes without valid data SHALL drive out_data lane = 0 and out_lane_valid bit = 0.
REQ-024 DRAIN SHALL last until lane LANES-1 of row N-1 is output (edge t+N+LANES+1), then go to DONE.
REQ-025 DONE SHALL pulse done=1 for exactly one cycle, deassert busy at the same edge, return to IDLE.
REQ-026 start while busy=1 SHALL be ignored, with no effect on latched parameters.
REQ-027 Row counter SHALL be ADDR_WIDTH+1 bits so num_rows=256 streams all rows exactly once.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE; busy, done, buf_rd_en, out_lane_valid, all skew registers and out_data to 0; buf_rd_addr to 0.
REQ-029 Reset mid-operation SHALL abort without a done pulse; start is accepted on the first edge after reset deasserts.

Verification
REQ-030 Single row: base_addr=0, num_rows=1, row0 lanes = 0x01..0x10 -> lane i = 0x01+i at t+3+i only; done at t+LANES+3.
REQ-031 Four rows from base 0x10, row k lane i = 16k+i -> each lane carries 4 consecutive values, lane i starting at t+3+i; out_lane_valid forms a diagonal band.
REQ-032 Wrap: base_addr=0xFE, num_rows=4 -> buf_rd_addr sequence 0xFE, 0xFF, 0x00, 0x01 on consecutive edges.
REQ-033 num_rows=0 -> buf_rd_en never asserted; done pulses one cycle after start; out_lane_valid stays 0.
REQ-034 start re-asserted with new base_addr while busy -> ignored; output stream and done timing match the first request only.
REQ-035 reset asserted at row 2 of an 8-row stream -> next edge all outputs 0, no done; new start after release runs a full correct stream.

Source files
------------

// File: rtl/data_setup.sv
// Reads a block of unified-buffer rows and feeds them to a systolic array with a
// one-cycle-per-lane diagonal skew; lane i of a row leaves i cycles after lane 0.
module data_setup #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH:0]           num_rows,
    output logic                          busy,
    output logic                          done,
    output logic                          buf_rd_en,
    output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
    input  logic [LANES*DATA_WIDTH-1:0]   buf_rd_data,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_lane_valid
);

    localparam int DRAIN_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_num_rows;
    logic [ADDR_WIDTH:0]   r_row_cnt;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_vld;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_last_row;
    logic                  w_drain_end;

    assign w_accept    = (r_state == IDLE) && start && (num_rows != '0);
    assign w_last_row  = (r_row_cnt == (r_num_rows - 1'b1));
    // Last lane of the last row leaves LANES+1 edges after the final read is issued.
    assign w_drain_end = (r_drain_cnt == DRAIN_W'(LANES));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (num_rows != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (w_last_row) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_end) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base      <= '0;
            r_num_rows  <= '0;
            r_row_cnt   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_vld    <= 1'b0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base     <= base_addr;
                r_num_rows <= num_rows;
                r_row_cnt  <= '0;
            end else if (r_state == READ) begin
                r_row_cnt  <= r_row_cnt + 1'b1;
            end

            r_rd_en <= (r_state == READ);
            if (r_state == READ) begin
                r_rd_addr <= r_base + r_row_cnt[ADDR_WIDTH-1:0];
            end

            // Marks the cycle in which buf_rd_data holds a requested row.
            r_rd_vld    <= r_rd_en;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 1'b1 : '0;
            r_done      <= (r_state == DONE);
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign buf_rd_en   = r_rd_en;
    assign buf_rd_addr = r_rd_addr;

    // Per lane: one capture stage followed by gi skew stages.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] r_stage [0:gi];
            logic [gi:0]           r_stage_vld;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int j = 0; j <= gi; j++) begin
                        r_stage[j] <= '0;
                    end
                    r_stage_vld <= '0;
                end else begin
                    r_stage[0]     <= r_rd_vld ? buf_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                    r_stage_vld[0] <= r_rd_vld;
                    for (int j = 1; j <= gi; j++) begin
                        r_stage[j]     <= r_stage[j-1];
                        r_stage_vld[j] <= r_stage_vld[j-1];
                    end
                end
            end

            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_stage[gi];
            assign out_lane_valid[gi]                    = r_stage_vld[gi];
        end
    endgenerate

endmodule

// File: tb/tb_data_setup.sv
// Scoreboard bench for data_setup: a request-level model predicts read
// addresses, skewed lane values and done timing; a monitor compares each cycle.
module tb_data_setup;

    localparam int L  = 16;
    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct { int cyc; logic [DW-1:0] data; } lane_ev_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } rd_ev_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       num_rows;
    logic              busy;
    logic              done;
    logic              buf_rd_en;
    logic [AW-1:0]     buf_rd_addr;
    logic [L*DW-1:0]   buf_rd_data;
    logic [L*DW-1:0]   out_data;
    logic [L-1:0]      out_lane_valid;

    data_setup #(.LANES(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_rows       (num_rows),
        .busy           (busy),
        .done           (done),
        .buf_rd_en      (buf_rd_en),
        .buf_rd_addr    (buf_rd_addr),
        .buf_rd_data    (buf_rd_data),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid)
    );

    logic [L*DW-1:0] mem [256];
    lane_ev_t        lane_q [L][$];
    rd_ev_t          rd_q [$];
    int              done_q [$];

    int cyc           = 0;
    int n_checks      = 0;
    int n_fail        = 0;
    int model_done    = -1;
    int busy_from     = 0;
    int busy_to       = 0;
    int rst_check_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency buffer model.
    always @(posedge clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request model: start sampled at edge t is accepted only after the previous done edge.
    task automatic issue(input logic [AW-1:0] b, input int n);
        int t;
        logic [AW-1:0]   a;
        logic [L*DW-1:0] row;
        lane_ev_t        le;
        rd_ev_t          re;
        t = cyc + 1;
        start     = 1'b1;
        base_addr = b;
        num_rows  = n[AW:0];
        if (t > model_done) begin
            for (int k = 0; k < n; k++) begin
                a = b + k[AW-1:0];
                re.cyc = t + 1 + k;
                re.addr = a;
                rd_q.push_back(re);
                row = mem[a];
                for (int i = 0; i < L; i++) begin
                    le.cyc  = t + 3 + k + i;
                    le.data = row[i*DW +: DW];
                    lane_q[i].push_back(le);
                end
            end
            model_done = (n == 0) ? t + 1 : t + n + L + 2;
            done_q.push_back(model_done);
            busy_from = t;
            busy_to   = model_done;
            $display("req  t=%0d base=0x%02h rows=%0d accepted done_at=%0d", t, b, n, model_done);
        end else begin
            $display("req  t=%0d base=0x%02h rows=%0d ignored (busy)", t, b, n);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        int r;
        reset = 1'b1;
        @(posedge clk); #1;
        r = cyc;
        for (int i = 0; i < L; i++)
            while (lane_q[i].size() > 0 && lane_q[i][$].cyc >= r) void'(lane_q[i].pop_back());
        while (rd_q.size() > 0 && rd_q[$].cyc >= r) void'(rd_q.pop_back());
        while (done_q.size() > 0 && done_q[$] >= r) void'(done_q.pop_back());
        if (model_done >= r) model_done = r;
        if (busy_to > r) busy_to = r;
        rst_check_cyc = r;
        reset = 1'b0;
        $display("rst  edge=%0d", r);
    endtask

    task automatic wait_idle();
        while (cyc <= model_done) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops expected events as the DUT presents them.
    always @(negedge clk) begin
        lane_ev_t le;
        rd_ev_t   re;
        int       dc;
        logic     zero_bad;
        if (cyc > 0) begin
            if (cyc == rst_check_cyc) begin
                check({busy, done, buf_rd_en} == 3'b000, "reset_ctrl", {busy, done, buf_rd_en}, 0);
                check(buf_rd_addr == '0, "reset_addr", buf_rd_addr, 0);
                check(out_lane_valid == '0, "reset_valid", out_lane_valid, 0);
                check(out_data == '0, "reset_data", out_data != '0, 0);
            end
            if (buf_rd_en) begin
                if (rd_q.size() == 0) begin
                    check(1'b0, "unexpected_rd", buf_rd_addr, 0);
                end else begin
                    re = rd_q.pop_front();
                    check(re.cyc == cyc, "rd_cycle", cyc, re.cyc);
                    check(buf_rd_addr == re.addr, "rd_addr", buf_rd_addr, re.addr);
                end
            end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                re = rd_q.pop_front();
                check(1'b0, "missing_rd", re.cyc, re.addr);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check(1'b0, "unexpected_done", cyc, 0);
                end else begin
                    dc = done_q.pop_front();
                    check(dc == cyc, "done_cycle", cyc, dc);
                    $display("done cycle=%0d", cyc);
                end
            end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                dc = done_q.pop_front();
                check(1'b0, "missing_done", cyc, dc);
            end
            zero_bad = 1'b0;
            for (int i = 0; i < L; i++) begin
                if (out_lane_valid[i]) begin
                    if (lane_q[i].size() == 0) begin
                        check(1'b0, $sformatf("unexpected_lane%0d", i), out_data[i*DW +: DW], 0);
                    end else begin
                        le = lane_q[i].pop_front();
                        check(le.cyc == cyc, $sformatf("lane%0d_cycle", i), cyc, le.cyc);
                        check(out_data[i*DW +: DW] == le.data, $sformatf("lane%0d_data", i),
                              out_data[i*DW +: DW], le.data);
                    end
                end else begin
                    if (lane_q[i].size() > 0 && lane_q[i][0].cyc <= cyc) begin
                        le = lane_q[i].pop_front();
                        check(1'b0, $sformatf("missing_lane%0d", i), le.cyc, le.data);
                    end
                    if (out_data[i*DW +: DW] != '0) zero_bad = 1'b1;
                end
            end
            check(!zero_bad, "idle_lane_zero", zero_bad, 0);
            check(busy == (cyc >= busy_from && cyc < busy_to), "busy", busy,
                  (cyc >= busy_from && cyc < busy_to));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int remaining;
        int gap;
        int n;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_rows    = '0;
        buf_rd_data = '0;
        for (int a = 0; a < 256; a++)
            for (int i = 0; i < L; i++) mem[a][i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < L; i++) mem[0][i*DW +: DW] = DW'(i + 1);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < L; i++) mem[8'h10 + k][i*DW +: DW] = DW'(16 * k + i);

        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset();

        issue(8'h00, 1);   wait_idle();
        issue(8'h10, 4);   wait_idle();
        issue(8'hFE, 4);   wait_idle();
        issue(8'h00, 0);   wait_idle();

        issue(8'h30, 5);
        repeat (3) begin @(posedge clk); #1; end
        issue(8'h80, 7);
        wait_idle();

        issue(8'h40, 8);
        repeat (2) begin @(posedge clk); #1; end
        do_reset();
        issue(8'h40, 8);   wait_idle();

        issue(8'h00, 256); wait_idle();

        for (int r = 0; r < 25; r++) begin
            gap = $urandom_range(0, 30);
            repeat (gap) begin @(posedge clk); #1; end
            n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
            issue(AW'($urandom), n);
        end
        wait_idle();
        repeat (L + 4) begin @(posedge clk); #1; end

        remaining = rd_q.size() + done_q.size();
        for (int i = 0; i < L; i++) remaining += lane_q[i].size();
        check(remaining == 0, "pending_events", remaining, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
